// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register indices, field positions, masks and vectors
// Purpose: constants shared by the CP0 register file and its timer.
// Ports: none (package).
package cp0_pkg;

  // flat CP0 indices as produced by the register-number decoder
  localparam logic [5:0] CP0_BADVADDR = 6'd8;
  localparam logic [5:0] CP0_COUNT    = 6'd9;
  localparam logic [5:0] CP0_COMPARE  = 6'd11;
  localparam logic [5:0] CP0_STATUS   = 6'd15;
  localparam logic [5:0] CP0_CAUSE    = 6'd16;
  localparam logic [5:0] CP0_EPC      = 6'd17;
  localparam logic [5:0] CP0_PRID     = 6'd19;
  localparam logic [5:0] CP0_CONFIG   = 6'd23;
  localparam logic [5:0] CP0_ERROREPC = 6'd37;

  // Status bit positions
  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  localparam int ST_ERL = 2;
  localparam int ST_IM  = 8;
  localparam int ST_BEV = 22;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam logic [31:0] STATUS_WMASK = 32'h0040_FF07;
  localparam logic [31:0] STATUS_RESET = 32'h0040_0004;
  localparam logic [31:0] VEC_BOOT     = 32'hBFC0_0380;
  localparam logic [31:0] VEC_NORMAL   = 32'h8000_0180;

endpackage

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - CP0 Count/Compare timer with prescaler and sticky TI
// Purpose: Count advances once every 2**COUNT_SHIFT cycles; TI is set when
//          Count steps onto Compare and cleared by a Compare write.
// Ports: clk, rst (sync active-high), count_we/compare_we load strobes,
//        wdata load value, count/compare register values, ti timer flag.
module cp0_timer #(
  parameter int COUNT_SHIFT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam int PW = (COUNT_SHIFT > 0) ? COUNT_SHIFT : 1;

  logic [PW-1:0] presc;
  logic          step;
  logic [31:0]   count_inc;

  // increment on the cycle the prescaler wraps
  assign step      = (COUNT_SHIFT == 0) ? 1'b1 : (presc == {PW{1'b1}});
  assign count_inc = count + 32'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      presc   <= '0;
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      if (count_we) begin
        // the written value wins over the increment in the same cycle
        count <= wdata;
        presc <= '0;
      end else begin
        presc <= presc + PW'(1);
        if (step) count <= count_inc;
      end
      if (compare_we) begin
        compare <= wdata;
        ti      <= 1'b0;
      end else if (!count_we && step && (count_inc == compare)) begin
        ti <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_regfile.sv
// rtl/cp0_regfile.sv - CP0 register storage, timer, exception and eret control
// Purpose: mfc0/mtc0 access by flat index, trap entry/eret state, interrupt pending.
// Ports: clk, rst (sync active-high); reg_num/rdata/we/wdata register access;
//        hw_int interrupt lines; exc_* exception entry; eret; irq_pending,
//        exc_vector, eret_target to the pipeline.
module cp0_regfile
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID        = 32'h0001_8000,
  parameter logic [31:0] CONFIG0     = 32'h8000_0000,
  parameter int          COUNT_SHIFT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  reg_num,
  output logic [31:0] rdata,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [5:0]  hw_int,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic [31:0] exc_badvaddr,
  input  logic        badvaddr_we,
  input  logic        eret,
  output logic        irq_pending,
  output logic [31:0] exc_vector,
  output logic [31:0] eret_target
);

  logic [31:0] status, epc, errorepc, badvaddr, cause;
  logic [31:0] count, compare;
  logic        cause_bd, ti;
  logic [5:0]  ip_hw;     // IP[7:2]
  logic [1:0]  ip_sw;     // IP[1:0]
  logic [4:0]  cause_code;
  logic        exl, erl;
  logic        wr;

  assign exl = status[ST_EXL];
  assign erl = status[ST_ERL];

  // mtc0 loses to a same-cycle exception or eret
  assign wr = we & ~exc_valid & ~eret;

  cp0_timer #(.COUNT_SHIFT(COUNT_SHIFT)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (wr && (reg_num == CP0_COUNT)),
    .compare_we (wr && (reg_num == CP0_COMPARE)),
    .wdata      (wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  assign cause = {cause_bd, ti, 14'd0, ip_hw, ip_sw, 1'b0, cause_code, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      status     <= STATUS_RESET;
      epc        <= '0;
      errorepc   <= '0;
      badvaddr   <= '0;
      cause_bd   <= 1'b0;
      ip_hw      <= '0;
      ip_sw      <= '0;
      cause_code <= '0;
    end else begin
      // IP7 carries the timer alongside hw_int[5]
      ip_hw <= {hw_int[5] | ti, hw_int[4:0]};
      if (exc_valid) begin
        cause_code     <= exc_code;
        status[ST_EXL] <= 1'b1;
        // nested exceptions keep the original return point
        if (!exl) begin
          epc      <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
          cause_bd <= exc_bd;
        end
        if (badvaddr_we) badvaddr <= exc_badvaddr;
      end else if (eret) begin
        if (erl) status[ST_ERL] <= 1'b0;
        else     status[ST_EXL] <= 1'b0;
      end else if (we) begin
        case (reg_num)
          CP0_STATUS:   status   <= (status & ~STATUS_WMASK) | (wdata & STATUS_WMASK);
          CP0_CAUSE:    ip_sw    <= wdata[9:8];
          CP0_EPC:      epc      <= wdata;
          CP0_ERROREPC: errorepc <= wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_num)
      CP0_BADVADDR: rdata = badvaddr;
      CP0_COUNT:    rdata = count;
      CP0_COMPARE:  rdata = compare;
      CP0_STATUS:   rdata = status;
      CP0_CAUSE:    rdata = cause;
      CP0_EPC:      rdata = epc;
      CP0_PRID:     rdata = PRID;
      CP0_CONFIG:   rdata = CONFIG0;
      CP0_ERROREPC: rdata = errorepc;
      default:      rdata = '0;
    endcase
  end

  assign irq_pending = status[ST_IE] & ~exl & ~erl & (|({ip_hw, ip_sw} & status[ST_IM +: 8]));
  assign exc_vector  = status[ST_BEV] ? VEC_BOOT : VEC_NORMAL;
  assign eret_target = erl ? errorepc : epc;

endmodule

// File: tb/tb_cp0_regfile.sv
// tb/tb_cp0_regfile.sv - scoreboard testbench for cp0_regfile
module tb_cp0_regfile;

  localparam int CS = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  reg_num = '0;
  logic [31:0] rdata;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic [5:0]  hw_int = '0;
  logic        exc_valid = 1'b0;
  logic [4:0]  exc_code = '0;
  logic [31:0] exc_pc = '0;
  logic        exc_bd = 1'b0;
  logic [31:0] exc_badvaddr = '0;
  logic        badvaddr_we = 1'b0;
  logic        eret = 1'b0;
  logic        irq_pending;
  logic [31:0] exc_vector;
  logic [31:0] eret_target;

  cp0_regfile #(.PRID(32'h0001_8000), .CONFIG0(32'h8000_0000), .COUNT_SHIFT(CS)) dut (
    .clk(clk), .rst(rst), .reg_num(reg_num), .rdata(rdata), .we(we), .wdata(wdata),
    .hw_int(hw_int), .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
    .exc_bd(exc_bd), .exc_badvaddr(exc_badvaddr), .badvaddr_we(badvaddr_we),
    .eret(eret), .irq_pending(irq_pending), .exc_vector(exc_vector),
    .eret_target(eret_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] rd;
    logic        irq;
    logic [31:0] vec;
    logic [31:0] tgt;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  string cur_tag = "init";

  // one-shot overrides: directed steps pin an output to a literal value
  bit o_rd_en, o_irq_en, o_vec_en, o_tgt_en;
  logic [31:0] o_rd, o_vec, o_tgt;
  logic o_irq;

  // reference model, architectural view
  logic [31:0] m_count, m_compare, m_status, m_epc, m_eepc, m_bva;
  int          m_phase;
  bit          m_ti, m_bd;
  logic [5:0]  m_iphw;
  logic [1:0]  m_ipsw;
  logic [4:0]  m_code;

  function automatic logic [31:0] m_read(input logic [5:0] r);
    case (r)
      8:  return m_bva;
      9:  return m_count;
      11: return m_compare;
      15: return m_status;
      16: return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_iphw) << 10)
               | (32'(m_ipsw) << 8) | (32'(m_code) << 2);
      17: return m_epc;
      19: return 32'h0001_8000;
      23: return 32'h8000_0000;
      37: return m_eepc;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_irq();
    logic [7:0] ip;
    ip = {m_iphw, m_ipsw};
    return m_status[0] && !m_status[1] && !m_status[2] && ((ip & m_status[15:8]) != 0);
  endfunction

  task automatic model_step();
    int p;
    bit w, inc, ti_old;
    if (rst) begin
      m_count = 0; m_compare = 0; m_phase = 0; m_ti = 0; m_status = 32'h0040_0004;
      m_epc = 0; m_eepc = 0; m_bva = 0; m_bd = 0; m_iphw = 0; m_ipsw = 0; m_code = 0;
      return;
    end
    p = 1 << CS;
    w = we && !exc_valid && !eret;
    ti_old = m_ti;
    inc = ((m_phase + 1) % p) == 0;
    if (w && reg_num == 9) begin
      m_count = wdata; m_phase = 0;
    end else begin
      m_phase = (m_phase + 1) % p;
      if (inc) begin
        m_count = m_count + 1;
        if (m_count == m_compare && !(w && reg_num == 11)) m_ti = 1;
      end
    end
    if (w && reg_num == 11) begin m_compare = wdata; m_ti = 0; end
    m_iphw = {hw_int[5] | ti_old, hw_int[4:0]};
    if (exc_valid) begin
      m_code = exc_code;
      if (!m_status[1]) begin
        m_epc = exc_bd ? exc_pc - 4 : exc_pc;
        m_bd  = exc_bd;
      end
      m_status[1] = 1'b1;
      if (badvaddr_we) m_bva = exc_badvaddr;
    end else if (eret) begin
      if (m_status[2]) m_status[2] = 1'b0; else m_status[1] = 1'b0;
    end else if (w) begin
      case (reg_num)
        15: m_status = (m_status & ~32'h0040_FF07) | (wdata & 32'h0040_FF07);
        16: m_ipsw = wdata[9:8];
        17: m_epc = wdata;
        37: m_eepc = wdata;
        default: ;
      endcase
    end
  endtask

  task automatic want_rd(input logic [31:0] v);  o_rd_en = 1;  o_rd = v;  endtask
  task automatic want_irq(input logic v);        o_irq_en = 1; o_irq = v; endtask
  task automatic want_vec(input logic [31:0] v); o_vec_en = 1; o_vec = v; endtask
  task automatic want_tgt(input logic [31:0] v); o_tgt_en = 1; o_tgt = v; endtask

  // issue one cycle: queue expectations for this cycle, advance the model, clock
  task automatic tick();
    exp_t e;
    if (!rst) begin
      e.tag = cur_tag;
      e.rd  = o_rd_en  ? o_rd  : m_read(reg_num);
      e.irq = o_irq_en ? o_irq : m_irq();
      e.vec = o_vec_en ? o_vec : (m_status[22] ? 32'hBFC0_0380 : 32'h8000_0180);
      e.tgt = o_tgt_en ? o_tgt : (m_status[2] ? m_eepc : m_epc);
      sbq.push_back(e);
    end
    o_rd_en = 0; o_irq_en = 0; o_vec_en = 0; o_tgt_en = 0;
    model_step();
    @(posedge clk);
    #1;
    we = 0; exc_valid = 0; eret = 0; badvaddr_we = 0;
  endtask

  task automatic rd(input int r);
    reg_num = 6'(r);
    tick();
  endtask

  task automatic wr(input int r, input logic [31:0] v);
    reg_num = 6'(r); we = 1; wdata = v;
    tick();
  endtask

  task automatic do_reset();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  task automatic chk(input string tag, input string what, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %h expected %h", tag, what, got, exp);
    end
  endtask

  // monitor: outputs are combinational, so each queued cycle is checked mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk(e.tag, "rdata", rdata, e.rd);
        chk(e.tag, "irq_pending", 32'(irq_pending), 32'(e.irq));
        chk(e.tag, "exc_vector", exc_vector, e.vec);
        chk(e.tag, "eret_target", eret_target, e.tgt);
      end
    end
  end

  int regs[10] = '{8, 9, 11, 15, 16, 17, 19, 23, 37, 0};
  int codes[7] = '{0, 4, 5, 8, 9, 10, 12};

  initial begin
    @(posedge clk); #1;
    do_reset();

    cur_tag = "reset";
    want_rd(0); rd(9);
    want_rd(32'h0040_0004); want_vec(32'hBFC0_0380); want_irq(0); want_tgt(0); rd(15);
    want_rd(0); rd(16);

    cur_tag = "timer";
    wr(15, 32'h0000_8001);
    wr(11, 10);
    wr(9, 0);
    for (int k = 1; k <= 20; k++) begin want_rd(32'((k - 1) / 2)); rd(9); end
    want_rd(32'h4000_0000); want_irq(0); rd(16);
    want_rd(10); want_irq(1); rd(9);
    want_irq(1); wr(11, 100);
    want_rd(32'h0000_8000); want_irq(1); rd(16);
    want_rd(0); want_irq(0); rd(16);

    cur_tag = "exc";
    exc_valid = 1; exc_pc = 32'h8000_1004; exc_bd = 1; exc_code = 5'd12;
    want_rd(32'h0000_8001); rd(15);
    want_rd(32'h8000_1000); want_vec(32'h8000_0180); rd(17);
    want_rd(32'h8000_0030); rd(16);
    want_rd(32'h0000_8003); want_irq(0); rd(15);
    exc_valid = 1; exc_pc = 32'h8000_2000; exc_bd = 0; exc_code = 5'd8;
    badvaddr_we = 1; exc_badvaddr = 32'h1234_5678;
    rd(17);
    want_rd(32'h8000_1000); rd(17);
    want_rd(32'h8000_0020); rd(16);
    want_rd(32'h1234_5678); rd(8);

    cur_tag = "priority";
    eret = 1; want_tgt(32'h8000_1000); rd(17);
    want_rd(32'h0000_8001); rd(15);
    exc_valid = 1; exc_pc = 32'h8000_3000; exc_bd = 0; exc_code = 5'd4; eret = 1;
    wr(15, 32'h0040_0000);
    want_rd(32'h0000_8003); want_vec(32'h8000_0180); rd(15);
    want_rd(32'h8000_3000); rd(17);
    want_rd(32'h0000_0010); rd(16);

    cur_tag = "hwint";
    eret = 1; rd(15);
    wr(15, 32'h0000_0401);
    hw_int = 6'b000001;
    want_rd(32'h0000_0401); want_irq(0); rd(15);
    want_rd(32'h0000_0410); want_irq(1); rd(16);
    want_irq(1); wr(15, 32'h0000_0403);
    want_irq(0); rd(15);
    hw_int = 0;

    cur_tag = "eret";
    do_reset();
    wr(15, 32'h0040_0006);
    wr(37, 32'hBFC0_1234);
    wr(17, 32'h8000_4000);
    eret = 1; want_rd(32'h0040_0006); want_tgt(32'hBFC0_1234); want_vec(32'hBFC0_0380); rd(15);
    eret = 1; want_rd(32'h0040_0002); want_tgt(32'h8000_4000); rd(15);
    want_rd(32'h0040_0000); rd(15);
    wr(8, 32'hFFFF_FFFF);
    wr(19, 32'h0);
    want_rd(0); rd(8);
    want_rd(32'h0001_8000); rd(19);
    want_rd(32'h8000_0000); rd(23);
    want_rd(0); rd(5);

    cur_tag = "random";
    for (int i = 0; i < 3000; i++) begin
      int idx;
      idx = $urandom_range(0, 9);
      reg_num = (idx == 9) ? 6'($urandom_range(0, 63)) : 6'(regs[idx]);
      if ($urandom_range(0, 99) < 30) begin
        we = 1;
        wdata = $urandom;
        if (reg_num == 15 && $urandom_range(0, 1) == 1) wdata = wdata & ~32'h6;
        if (reg_num == 11 && $urandom_range(0, 1) == 1) wdata = m_count + 32'($urandom_range(1, 6));
      end
      if ($urandom_range(0, 99) < 6) begin
        exc_valid = 1;
        exc_code = 5'(codes[$urandom_range(0, 6)]);
        exc_pc = $urandom;
        exc_bd = 1'($urandom_range(0, 1));
        exc_badvaddr = $urandom;
        badvaddr_we = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 99) < 6) eret = 1;
      if ($urandom_range(0, 99) < 10) hw_int = 6'($urandom);
      tick();
    end

    cur_tag = "midreset";
    reg_num = 15; we = 1; wdata = 32'hFFFF_FFFF; exc_valid = 1; eret = 1; rst = 1;
    tick();
    rst = 0; hw_int = 0;
    want_rd(32'h0040_0004); want_tgt(0); want_vec(32'hBFC0_0380); want_irq(0); rd(15);
    want_rd(0); rd(17);
    want_rd(0); rd(16);

    repeat (3) @(negedge clk);
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d entries left expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
